// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the EX stage: fixed-latency multiply, 32-step restoring divide,
// MTHI/MTLO writes and stall generation for HI/LO-dependent instructions.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  MULT,
  input  logic [1:0]  DIV,
  input  logic [1:0]  MFHL,
  input  logic [1:0]  MTHL,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sgn;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_hl_op;
  logic        w_launch;
  logic        w_mthl_we;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_hl_op    = op_valid & (|{MULT, DIV, MFHL, MTHL});
  assign busy       = (r_state != S_IDLE);
  assign stall      = w_hl_op & busy & ~flush;
  assign w_launch   = op_valid & ~flush & ~busy;
  assign w_mthl_we  = op_valid & ~stall & ~flush;

  assign w_a_ext    = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_b_ext    = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod     = w_a_ext * w_b_ext;

  // During a divide r_a shifts the dividend out at the top and the quotient in at the bottom.
  assign w_shift    = {r_rem, r_a[31]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_diff     = w_shift[31:0] - r_b;

  assign w_abs_a    = (DIV[0] & src_a[31]) ? -src_a : src_a;
  assign w_abs_b    = (DIV[0] & src_b[31]) ? -src_b : src_b;
  assign w_q_fix    = r_neg_q ? -r_a : r_a;
  assign w_r_fix    = r_neg_r ? -r_rem : r_rem;

  assign hi         = r_hi;
  assign lo         = r_lo;
  assign hilo_rdata = MFHL[1] ? r_hi : r_lo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            if (|MULT) begin
              r_a     <= src_a;
              r_b     <= src_b;
              r_sgn   <= MULT[0];
              r_cnt   <= 6'(MUL_LAT - 1);
              r_state <= S_MUL;
            end else if (|DIV) begin
              r_a     <= w_abs_a;
              r_b     <= w_abs_b;
              r_rem   <= '0;
              r_neg_q <= DIV[0] & (src_a[31] ^ src_b[31]);
              r_neg_r <= DIV[0] & src_a[31];
              r_cnt   <= 6'd32;
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 6'd0) begin
            {r_hi, r_lo} <= w_prod;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 6'd0) begin
            r_hi    <= w_r_fix;
            r_lo    <= w_q_fix;
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_ge ? w_diff : w_shift[31:0];
            r_a   <= {r_a[30:0], w_ge};
            r_cnt <= r_cnt - 6'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Any MTHL that reaches here is unstalled, so it can never collide with a result write.
      if (w_mthl_we & MTHL[1]) r_hi <= src_a;
      if (w_mthl_we & MTHL[0]) r_lo <= src_a;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: result table, directed timing sequences,
// then random instruction streams against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [1:0]  MULT, DIV, MFHL, MTHL;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall, busy;
  logic [31:0] hilo_rdata, hi, lo;

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .op_valid   (op_valid),
    .MULT       (MULT),
    .DIV        (DIV),
    .MFHL       (MFHL),
    .MTHL       (MTHL),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  mult;
    logic [1:0]  div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt;

  // reference model state
  int          m_left;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  logic        m_busy, m_stall, hl;
  logic [63:0] res;
  int          k;
  logic        ov, fl;
  logic [1:0]  mu, dv, mf, mt;
  logic [31:0] ra, rb;

  task automatic add(input string nm, input logic [1:0] mul, input logic [1:0] dvv,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.name = nm; v.mult = mul; v.div = dvv; v.a = a; v.b = b; v.e_hi = eh; v.e_lo = el;
    tbl.push_back(v);
  endtask

  task automatic setin(input logic v, input logic [1:0] mul, input logic [1:0] dvv,
                       input logic [1:0] mfv, input logic [1:0] mtv,
                       input logic [31:0] a, input logic [31:0] b, input logic f);
    op_valid = v; MULT = mul; DIV = dvv; MFHL = mfv; MTHL = mtv;
    src_a = a; src_b = b; flush = f;
  endtask

  task automatic idle_in();
    setin(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // returns {remainder, quotient}
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    if (b == 32'd0) return {a, ((sgn && a[31]) ? 32'd1 : 32'hFFFFFFFF)};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add("mult_m2x3",    2'b01, 2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
    add("div_ovf",      2'b00, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    add("div_m7_2",     2'b00, 2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    add("divu_7_0",     2'b00, 2'b10, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
    add("divu_100_7",   2'b00, 2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    add("multu_5x5",    2'b10, 2'b00, 32'd5,        32'd5,        32'h00000000, 32'h00000019);
    add("multu_max",    2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    add("mult_minsq",   2'b01, 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    add("div_7_m2",     2'b00, 2'b01, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    add("div_m8_0",     2'b00, 2'b01, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'h00000001);
    add("mult_7xm1",    2'b01, 2'b00, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9);
    add("divu_max_1",   2'b00, 2'b10, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF);

    // reset state
    resetn = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // result table, each launched from idle
    foreach (tbl[i]) begin
      @(negedge clk);
      setin(1'b1, tbl[i].mult, tbl[i].div, 2'b00, 2'b00, tbl[i].a, tbl[i].b, 1'b0);
      #1 chk({tbl[i].name, "_launch_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      idle_in();
      cnt = 0;
      while (cnt < 40) begin
        #1;
        if (!busy) break;
        cnt++;
        @(negedge clk);
      end
      chk({tbl[i].name, "_busy_cycles"}, 32'(cnt), (|tbl[i].mult) ? 32'(MUL_LAT) : 32'd33);
      chk({tbl[i].name, "_hi"}, hi, tbl[i].e_hi);
      chk({tbl[i].name, "_lo"}, lo, tbl[i].e_lo);
    end

    // mult followed immediately by a dependent mfhi
    @(negedge clk);
    setin(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd3, 1'b0);
    #1 chk("mfhi_launch_stall", 32'(stall), 32'd0);
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 32'd0, 32'd0, 1'b0);
    #1 chk("mfhi_stall_t1", 32'(stall), 32'd1);
    @(negedge clk);
    #1 chk("mfhi_stall_t2", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    chk("mfhi_stall_t3", 32'(stall), 32'd0);
    chk("mfhi_busy_t3", 32'(busy), 32'd0);
    chk("mfhi_rdata", hilo_rdata, 32'hFFFFFFFF);
    chk("mfhi_lo", lo, 32'hFFFFFFFA);

    // divu then back-to-back multu
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    setin(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 32'd5, 32'd5, 1'b0);
    cnt = 0;
    while (cnt < 40) begin
      #1;
      if (!stall) break;
      cnt++;
      @(negedge clk);
    end
    chk("b2b_stall_cycles", 32'(cnt), 32'd33);
    chk("b2b_mid_hi", hi, 32'd2);
    chk("b2b_mid_lo", lo, 32'd14);
    @(negedge clk);
    idle_in();
    cnt = 0;
    while (cnt < 10) begin
      #1;
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    chk("b2b_mul_cycles", 32'(cnt), 32'(MUL_LAT));
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd25);

    // mthi while idle
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 32'h1234, 32'd0, 1'b0);
    #1 chk("mthi_stall", 32'(stall), 32'd0);
    @(negedge clk);
    idle_in();
    #1 chk("mthi_hi", hi, 32'h1234);

    // mtlo held behind a divide
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 32'hBEEF, 32'd0, 1'b0);
    cnt = 0;
    while (cnt < 40) begin
      #1;
      if (!stall) break;
      cnt++;
      @(negedge clk);
    end
    chk("mtlo_stall_cycles", 32'(cnt), 32'd33);
    @(negedge clk);
    idle_in();
    #1;
    chk("mtlo_lo", lo, 32'hBEEF);
    chk("mtlo_hi", hi, 32'd2);

    // flush mid-divide
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 32'hA5A5A5A5, 32'd0, 1'b0);
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    idle_in();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_busy_t10", 32'(busy), 32'd1);
    chk("flush_stall_t10", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy_t11", 32'(busy), 32'd0);
    chk("flush_hi", hi, 32'hA5A5A5A5);
    chk("flush_lo", lo, 32'hA5A5A5A5);
    @(negedge clk);
    setin(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    idle_in();
    #1 chk("flush_mult_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("flush_mult_hi", hi, 32'hA5A5A5A5);
    chk("flush_mult_lo", lo, 32'hA5A5A5A5);

    // reset in the middle of a divide
    @(negedge clk);
    setin(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    idle_in();
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    setin(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 32'd0, 32'd0, 1'b0);
    #1;
    chk("midrst_mflo_stall", 32'(stall), 32'd0);
    chk("midrst_mflo_rdata", hilo_rdata, 32'd0);

    // random instruction stream against the reference model
    m_left = 0; m_hi = '0; m_lo = '0; m_rhi = '0; m_rlo = '0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      k  = int'($urandom_range(0, 11));
      ov = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 29) == 0);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      mu = (k == 1) ? 2'b01 : (k == 2) ? 2'b10 : 2'b00;
      dv = (k == 3) ? 2'b01 : (k == 4) ? 2'b10 : 2'b00;
      mf = (k == 5) ? 2'b10 : (k == 6) ? 2'b01 : 2'b00;
      mt = (k == 7) ? 2'b10 : (k == 8) ? 2'b01 : 2'b00;
      setin(ov, mu, dv, mf, mt, ra, rb, fl);
      hl      = ov & (k >= 1) & (k <= 8);
      m_busy  = (m_left > 0);
      m_stall = hl & m_busy & ~fl;
      #1;
      chk("rnd_busy", 32'(busy), 32'(m_busy));
      chk("rnd_stall", 32'(stall), 32'(m_stall));
      chk("rnd_hi", hi, m_hi);
      chk("rnd_lo", lo, m_lo);
      if (!m_stall) chk("rnd_rdata", hilo_rdata, mf[1] ? m_hi : m_lo);

      if (m_busy) begin
        if (fl) m_left = 0;
        else if (m_left == 1) begin
          m_hi = m_rhi; m_lo = m_rlo; m_left = 0;
        end else m_left--;
      end else if (ov && !fl) begin
        if (k == 1 || k == 2) begin
          res = mul_ref(ra, rb, k == 1);
          {m_rhi, m_rlo} = res;
          m_left = MUL_LAT;
        end else if (k == 3 || k == 4) begin
          res = div_ref(ra, rb, k == 3);
          {m_rhi, m_rlo} = res;
          m_left = 33;
        end
      end
      if (ov && !m_stall && !fl && k == 7) m_hi = ra;
      if (ov && !m_stall && !fl && k == 8) m_lo = ra;
    end

    @(negedge clk);
    idle_in();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer and owner of the HI/LO register pair for the five-stage MIPS core. Sits in EX next to the ALU, consumes the decoded MULT, DIV, MFHL and MTHL fields, and runs multiplies at fixed latency and divides with an internal 32-step restoring divider. MULT/DIV issue non-blocking. Only a later HI/LO-dependent instruction is stalled while an operation is in flight.

## Interface
Parameters:
- MUL_LAT, 2, multiply latency in cycles (1..4); busy cycles per multiply

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  EX holds a valid, unflushed instruction
- MULT  in  2  [1] multu, [0] mult (one-hot or zero)
- DIV  in  2  [1] divu, [0] div
- MFHL  in  2  [1] mfhi, [0] mflo
- MTHL  in  2  [1] mthi, [0] mtlo
- src_a  in  32  rs value (dividend / multiplicand / MTHL data)
- src_b  in  32  rt value (divisor / multiplier)
- flush  in  1  exception/eret flush of EX and in-flight operation
- stall  out  1  hold EX and earlier stages this cycle
- busy  out  1  operation in flight
- hilo_rdata  out  32  HI if MFHL[1], else LO
- hi, lo  out  32  architectural HI/LO

## Operation
- States: IDLE, MUL, DIV. busy = (state != IDLE).
- Define hl_op = op_valid & |{MULT, DIV, MFHL, MTHL}. stall = hl_op & busy & ~flush (combinational).
- Launch: in IDLE with op_valid & ~flush & |MULT: capture src_a/src_b and sign mode, counter <= MUL_LAT-1, go to MUL. |DIV: capture, counter <= 32, go to DIV.
- MUL: 64-bit product, signed for mult, unsigned for multu. On the cycle counter==0, write {HI,LO} <= product and return to IDLE. Otherwise decrement.
- DIV: take magnitudes for div, raw values for divu. 32 restoring iterations, one quotient bit per cycle (counter 32..1). When counter==0, do the sign fixup: quotient negated iff operand signs differ, remainder takes dividend sign. Write HI <= remainder, LO <= quotient, return to IDLE.
- Divide by zero raises no exception and produces the algorithm result. divu x/0 gives LO=0xFFFFFFFF, HI=x.
- MTHL with op_valid & ~stall & ~flush writes src_a to HI (MTHL[1]) or LO (MTHL[0]) at the clock edge.
- hilo_rdata reads the registers combinationally. It is meaningful only when stall=0.
- flush: a same-cycle launch or MTHL write is suppressed. If busy, abort to IDLE at the next edge. HI/LO keep their pre-operation values.
- Reset, including mid-operation: state=IDLE, hi=lo=0, counters 0, busy=0. stall follows its equation, so it is 0 while busy=0.

## Timing
- Launch at the edge ending cycle T. busy=1 during T+1..T+MUL_LAT (multiply) or T+1..T+33 (divide).
- Result is written at the edge ending the last busy cycle and is visible on hi/lo/hilo_rdata the following cycle.
- A dependent instruction presented in T+1 stalls through the last busy cycle. It proceeds in the first cycle busy=0 and sees the new value.
- A MULT/DIV presented while busy stalls. It launches in the first idle cycle, with no gap cycle required.
- The launching instruction itself never stalls. stall is 0 whenever op_valid=0.
- Divide total: 33 busy cycles. Multiply total: MUL_LAT busy cycles.

## Test plan
- mult 0xFFFFFFFE x 3 (MUL_LAT=2), mfhi at T+1 -> stall high T+1..T+2. In T+3: HI=0xFFFFFFFF, LO=0xFFFFFFFA, hilo_rdata=0xFFFFFFFF, stall=0.
- div 0x80000000 / 0xFFFFFFFF -> busy 33 cycles, LO=0x80000000, HI=0. div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> LO=0xFFFFFFFF, HI=7.
- divu 100/7 at T, multu 5x5 at T+1 -> multu stalls T+1..T+33, launches T+34. Final HI=0, LO=25 (divide result overwritten; intermediate HI=2, LO=14 visible T+34).
- mthi 0x1234 while idle -> HI=0x1234 next cycle, no stall. mtlo during busy divide -> stall until divide completes, then LO=src_a, overwriting the quotient.
- flush in T+10 of a divide with HI=LO=0xA5A5A5A5 -> busy=0 at T+11, HI/LO unchanged. mult with flush in the same cycle -> no launch.
- resetn low at T+5 of a divide -> immediately busy=0, hi=lo=0. After release, mflo returns 0 with no stall.
